// File: rtl/free_list_pkg.sv
// Shared types and sizing for the rename free list: tag widths, wrap-bit pointers,
// and the packed request/response bundles exchanged with dispatch and the map table.
package free_list_pkg;

    localparam int NUM_PR   = 64;
    localparam int NUM_ARCH = 32;
    localparam int NUM_FL   = NUM_PR - NUM_ARCH;
    localparam int NUM_ROB  = 8;

    localparam int PR_W     = $clog2(NUM_PR);
    localparam int ROB_W    = $clog2(NUM_ROB);
    localparam int FL_IDX_W = $clog2(NUM_FL);
    localparam int FL_PTR_W = FL_IDX_W + 1;

    typedef logic [PR_W-1:0]     T_t;
    typedef logic [ROB_W-1:0]    ROB_idx_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;

    typedef struct packed {
        logic     dispatch_en;
        ROB_idx_t ROB_tail_idx;
        logic     retire_en;
        T_t       retire_T_old;
        logic     rollback_en;
        ROB_idx_t ROB_rollback_idx;
    } FREE_LIST_PACKET_IN;

    typedef struct packed {
        T_t      T_idx;
        logic    free_valid;
        fl_ptr_t free_count;
    } FREE_LIST_PACKET_OUT;

    // Outputs seen in the cycle after reset: full list, first non-architectural tag at head.
    localparam FREE_LIST_PACKET_OUT FREE_LIST_RESET = '{
        T_idx:      T_t'(NUM_ARCH),
        free_valid: 1'b1,
        free_count: fl_ptr_t'(NUM_FL)
    };

endpackage

// File: rtl/free_list.sv
// Circular free-tag FIFO for rename: pops on dispatch, pushes on retire, and restores
// its head from a per-ROB-entry checkpoint in one cycle on branch rollback.
module free_list
    import free_list_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     en,
    input  logic     dispatch_en,
    input  ROB_idx_t ROB_tail_idx,
    input  logic     retire_en,
    input  T_t       retire_T_old,
    input  logic     rollback_en,
    input  ROB_idx_t ROB_rollback_idx,
    output T_t       T_idx,
    output logic     free_valid,
    output fl_ptr_t  free_count
);

    T_t      fl_q   [NUM_FL];
    T_t      fl_d   [NUM_FL];
    fl_ptr_t ckpt_q [NUM_ROB];
    fl_ptr_t ckpt_d [NUM_ROB];
    fl_ptr_t head_q, head_d;
    fl_ptr_t tail_q, tail_d;
    fl_ptr_t count;
    logic    pop;

    FREE_LIST_PACKET_IN  pkt_in;
    FREE_LIST_PACKET_OUT pkt_out;

    always_comb begin
        pkt_in = '{
            dispatch_en:      dispatch_en,
            ROB_tail_idx:     ROB_tail_idx,
            retire_en:        retire_en,
            retire_T_old:     retire_T_old,
            rollback_en:      rollback_en,
            ROB_rollback_idx: ROB_rollback_idx
        };
        // Wrap bit makes tail-head the exact occupancy, full and empty included.
        count              = tail_q - head_q;
        pkt_out.T_idx      = fl_q[head_q[FL_IDX_W-1:0]];
        pkt_out.free_valid = (count != '0);
        pkt_out.free_count = count;
    end

    assign T_idx      = pkt_out.T_idx;
    assign free_valid = pkt_out.free_valid;
    assign free_count = pkt_out.free_count;

    always_comb begin
        fl_d   = fl_q;
        ckpt_d = ckpt_q;
        head_d = head_q;
        tail_d = tail_q;
        // A rollback squashes the same-cycle dispatch; popping an empty list is ignored.
        pop    = pkt_in.dispatch_en && pkt_out.free_valid && !pkt_in.rollback_en;
        if (en) begin
            if (pkt_in.rollback_en) begin
                head_d = ckpt_q[pkt_in.ROB_rollback_idx];
            end else if (pop) begin
                head_d                      = head_q + fl_ptr_t'(1);
                ckpt_d[pkt_in.ROB_tail_idx] = head_q + fl_ptr_t'(1);
            end
            // The retiring instruction is older than any rolled-back branch, so its push always lands.
            if (pkt_in.retire_en) begin
                fl_d[tail_q[FL_IDX_W-1:0]] = pkt_in.retire_T_old;
                tail_d                     = tail_q + fl_ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_FL; i++) begin
                fl_q[i] <= T_t'(NUM_ARCH + i);
            end
            for (int i = 0; i < NUM_ROB; i++) begin
                ckpt_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= fl_ptr_t'(NUM_FL);
        end else begin
            fl_q   <= fl_d;
            ckpt_q <= ckpt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Live architectural mappings bound occupancy; exceeding capacity means upstream misbehaved.
    no_overflow: assert property (@(posedge clock) disable iff (reset)
        (fl_ptr_t'(tail_d - head_d) <= fl_ptr_t'(NUM_FL)));

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed vector table, hand-written empty-list sequence, and
// randomized traffic checked against an absolute-position reference model.
module tb_free_list;
    import free_list_pkg::*;

    logic     clock = 1'b0;
    logic     reset, en, dispatch_en, retire_en, rollback_en;
    ROB_idx_t ROB_tail_idx, ROB_rollback_idx;
    T_t       retire_T_old;
    T_t       T_idx;
    logic     free_valid;
    fl_ptr_t  free_count;

    int n_cmp = 0;
    int n_bad = 0;

    free_list dut (
        .clock            (clock),
        .reset            (reset),
        .en               (en),
        .dispatch_en      (dispatch_en),
        .ROB_tail_idx     (ROB_tail_idx),
        .retire_en        (retire_en),
        .retire_T_old     (retire_T_old),
        .rollback_en      (rollback_en),
        .ROB_rollback_idx (ROB_rollback_idx),
        .T_idx            (T_idx),
        .free_valid       (free_valid),
        .free_count       (free_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic rst, ena, disp;
        int   rob_t;
        logic ret;
        int   tag;
        logic rb;
        int   rob_rb;
        int   exp_t, exp_v, exp_c;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int et, input int ev, input int ec);
        if (et >= 0) check({name, " T_idx"}, int'(T_idx), et);
        check({name, " free_valid"}, int'(free_valid), ev);
        check({name, " free_count"}, int'(free_count), ec);
    endtask

    task automatic apply(input logic r, input logic e, input logic d, input int rt,
                         input logic ret, input int tag, input logic rb, input int rbi);
        reset            = r;
        en               = e;
        dispatch_en      = d;
        ROB_tail_idx     = ROB_idx_t'(rt);
        retire_en        = ret;
        retire_T_old     = T_t'(tag);
        rollback_en      = rb;
        ROB_rollback_idx = ROB_idx_t'(rbi);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        apply(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        step();
        apply(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    // Reference model: absolute (never-wrapping) positions; tags stored by absolute slot.
    int  mem [int];
    int  h, t;
    int  ck    [NUM_ROB];
    bit  ck_ok [NUM_ROB];

    initial begin
        logic e, d, ret, rb, pop;
        int   rt, rbi, tag, nh, cnt;

        // Rows: rst en disp rob_t ret tag rb rob_rb | expected T_idx valid count after the edge
        vecs.push_back('{0, 1, 1, 0, 0,  0, 0, 0, 33, 1, 31});
        vecs.push_back('{0, 1, 1, 1, 0,  0, 0, 0, 34, 1, 30});
        vecs.push_back('{0, 1, 1, 2, 0,  0, 0, 0, 35, 1, 29});
        vecs.push_back('{0, 1, 1, 3, 0,  0, 0, 0, 36, 1, 28});
        vecs.push_back('{0, 1, 1, 4, 0,  0, 0, 0, 37, 1, 27});
        vecs.push_back('{0, 1, 1, 5, 0,  0, 0, 0, 38, 1, 26});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 1, 1, 34, 1, 30});
        vecs.push_back('{0, 1, 1, 5, 1,  9, 1, 2, 35, 1, 30});
        vecs.push_back('{0, 1, 1, 3, 0,  0, 0, 0, 36, 1, 29});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 1, 5, 38, 1, 27});
        vecs.push_back('{0, 1, 1, 6, 1,  7, 0, 0, 39, 1, 27});
        vecs.push_back('{0, 0, 1, 7, 1,  3, 1, 0, 39, 1, 27});
        vecs.push_back('{0, 1, 0, 0, 1, 11, 1, 3, 36, 1, 31});
        vecs.push_back('{1, 1, 1, 0, 1,  4, 0, 0, 32, 1, 32});
        vecs.push_back('{0, 1, 1, 0, 0,  0, 0, 0, 33, 1, 31});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 1, 2, 32, 1, 32});

        do_reset();
        check_out("reset", 32, 1, 32);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].ena, vecs[i].disp, vecs[i].rob_t,
                  vecs[i].ret, vecs[i].tag, vecs[i].rb, vecs[i].rob_rb);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_t, vecs[i].exp_v, vecs[i].exp_c);
        end

        // Drain to empty, try one more pop, then refill with one tag and roll back.
        do_reset();
        for (int i = 0; i < NUM_FL; i++) begin
            apply(0, 1, 1, i % NUM_ROB, 0, 0, 0, 0);
            step();
        end
        check_out("drained", -1, 0, 0);
        apply(0, 1, 1, 0, 0, 0, 0, 0);
        step();
        check_out("pop_empty", -1, 0, 0);
        apply(0, 1, 0, 0, 1, 5, 0, 0);
        step();
        check_out("push_into_empty", 5, 1, 1);
        apply(0, 1, 0, 0, 0, 0, 1, 0);
        step();
        check_out("rollback_after_empty", 57, 1, 8);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < NUM_FL; i++) mem[i] = NUM_ARCH + i;
        h = 0;
        t = NUM_FL;
        for (int i = 0; i < NUM_ROB; i++) begin
            ck[i]    = 0;
            ck_ok[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            e   = ($urandom_range(9) != 0);
            d   = $urandom_range(1);
            ret = $urandom_range(1);
            rb  = ($urandom_range(7) == 0);
            rt  = $urandom_range(NUM_ROB - 1);
            rbi = $urandom_range(NUM_ROB - 1);
            tag = $urandom_range(NUM_PR - 1);
            // Only roll back to checkpoints that are real and whose tags are still intact.
            if (rb && (!ck_ok[rbi] || ck[rbi] > h || (t + int'(ret) - ck[rbi]) > NUM_FL)) rb = 0;
            pop = d && !rb && (t > h);
            nh  = rb ? ck[rbi] : h + int'(pop);
            if (ret && (t + 1 - nh) > NUM_FL) ret = 0;
            apply(0, e, d, rt, ret, tag, rb, rbi);
            step();
            if (e) begin
                if (ret) begin
                    mem[t] = tag;
                    t++;
                end
                if (rb) begin
                    h = ck[rbi];
                end else if (pop) begin
                    h++;
                    ck[rt]    = h;
                    ck_ok[rt] = 1;
                end
            end
            cnt = t - h;
            check_out($sformatf("rand%0d", cyc), (cnt > 0) ? mem[h] : -1, (cnt > 0) ? 1 : 0, cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/free_list.md
# free_list

Circular FIFO of free physical-register tags feeding rename, directly upstream of the map table. Each dispatch pops one tag as the new destination `T_idx`. Each retirement pushes the retiring instruction's `T_old` back. A per-ROB-entry head checkpoint restores the list in one cycle on branch rollback, in lockstep with the map table's backup.

## Interface
Parameters:
- `NUM_PR`, 64: physical registers.
- `NUM_ARCH`, 32: architectural registers, always mapped.
- `NUM_FL`, `NUM_PR-NUM_ARCH` (32): list capacity.
- `NUM_ROB`, 8: checkpoint slots, one per ROB entry.

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: global stall; no state update when low.
- `dispatch_en` in 1: pop one tag this cycle.
- `ROB_tail_idx` in log2(NUM_ROB): ROB entry being allocated by this dispatch.
- `retire_en` in 1: push `retire_T_old` this cycle.
- `retire_T_old` in log2(NUM_PR): tag being freed.
- `rollback_en` in 1: restore to the checkpoint of `ROB_rollback_idx`.
- `ROB_rollback_idx` in log2(NUM_ROB): surviving (mispredicted branch) entry.
- `T_idx` out log2(NUM_PR): tag at head.
- `free_valid` out 1: list non-empty.
- `free_count` out log2(NUM_FL)+1: number of free tags.

## Operation
- Storage: `fl[NUM_FL]` of tags.
- Pointers `head` and `tail` are each log2(NUM_FL)+1 bits: index bits plus a wrap bit.
- `count = tail - head`, computed modulo 2^(log2(NUM_FL)+1).
- Reset state:
  - `fl[i] = NUM_ARCH+i`.
  - `head = 0`.
  - `tail = NUM_FL` (index 0, wrap bit 1).
  - All checkpoints = 0.
  - Outputs after reset: `T_idx=32`, `free_valid=1`, `free_count=32`.
- Dispatch, effective when `dispatch_en && free_valid && !rollback_en`:
  - `head <= head+1`.
  - `ckpt[ROB_tail_idx] <= head+1`.
- `dispatch_en` with an empty list is ignored: no pop, no checkpoint write. Upstream must gate on `free_valid`.
- Retire, when `retire_en`:
  - `fl[tail.idx] <= retire_T_old`.
  - `tail <= tail+1`.
  - Push never overflows, because the NUM_ARCH live mappings guarantee count ≤ NUM_FL. Overflow is an assertion failure, not handled.
- Rollback, when `rollback_en`: `head <= ckpt[ROB_rollback_idx]`.
  - Tags popped after that branch are re-exposed in place.
  - `fl` contents are never overwritten between the restored head and the old head, since tail cannot pass them.
- Simultaneous events:
  - dispatch+retire: both apply; count unchanged.
  - rollback+dispatch: rollback wins; dispatch dropped (squashed).
  - rollback+retire: both apply, because the retiring instruction is older than the branch.
  - All three: rollback+retire.
- No same-cycle bypass from a retire push into an empty list: `free_valid` reflects registered state only.
- `en=0` freezes all state regardless of other inputs.

## Timing
- Outputs are combinational from registered state only. No input-to-output paths.
- Pop, push and rollback are visible on outputs the cycle after the qualifying edge.
- Reset mid-operation discards all pointers and checkpoints on the next edge. Outputs show the reset values in the following cycle.
- Pointer and checkpoint arithmetic wraps naturally at 2^(log2(NUM_FL)+1).

## Structure
- Shared package:
  - `T_t`.
  - `NUM_PR`, `NUM_FL`, `NUM_ROB`.
  - `FREE_LIST_PACKET_IN` (dispatch_en, ROB_tail_idx, retire_en, retire_T_old, rollback_en, ROB_rollback_idx).
  - `FREE_LIST_PACKET_OUT` (T_idx, free_valid, free_count).
  - `FREE_LIST_RESET` constant.
- Single module with next-state `always_comb` and `always_ff`.
- No sub-module. The checkpoint array is inline.

## Test plan
- Reset then 3 dispatches (ROB 0,1,2) -> `T_idx` 32,33,34 on successive cycles; `free_count` 29; `ckpt[2]=3`.
- 32 dispatches -> `free_valid=0`, `free_count=0`. A 33rd `dispatch_en` leaves `head` unchanged. Then retire tag 5 -> next cycle `T_idx=5`, `count=1`.
- Dispatch on ROB 0..4, rollback to ROB 1 -> `head=2`, `T_idx=34`, `free_count=30`.
- Dispatch+retire(tag 7) in the same cycle from 20 free -> count stays 20, `T_idx` advances by one, tag 7 written at the old tail.
- rollback+dispatch+retire(tag 9) together -> head = checkpoint, no new checkpoint written, count = (tail+1) - checkpoint.
- Wrap: 40 interleaved pop/push cycles crossing index 31→0 -> tags returned in FIFO order. `en=0` for 3 cycles mid-sequence -> outputs frozen.
